// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
// UART_RX_PARITY_EN enables the parity state in the receiver.
package uart_pkg;

  localparam int DATA_BITS_DEF    = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity over up to nine bits; narrower words are zero-extended.
  function automatic logic parity9(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Parallel-side interface of the UART receiver: word handshake plus status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_unit_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  data_ready,
    output data_out, data_valid, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );

  modport slave (
    output data_ready,
    input  data_out, data_valid, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_unit_sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_unit.sv
// UART receive stage: synchronises rx, deframes LSB-first words, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD selects odd parity).
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_unit_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP   = ST_STOP;

  logic                 rx_s;
  logic                 rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
  logic                 word_ok_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Without parity checking par_bad_q stays low, so a good stop bit is enough.
  assign word_ok_s = rx_s && !par_bad_q;

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q && !bus.data_ready;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_bad_d = 1'b0;
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ parity9(9'(shift_q)) ^ PARITY_ODD;
          state_d   = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          ferr_d  = !rx_s;
          perr_d  = par_bad_q;
          if (!word_ok_s) begin
            valid_d = valid_q && !bus.data_ready;
          end else if (!valid_q || bus.data_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit with default parameters (8 data bits, 16 clk per bit).
// Also covers the parity path when UART_RX_PARITY_EN is defined.
module tb_uart_rx_unit;

`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic clk;
  logic reset;
  logic rx;
`ifdef UART_RX_PARITY_EN
  logic bad_par;
`endif

  uart_rx_unit_if #(.DATA_BITS(8)) bus ();

  uart_rx_unit dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: event counters read as deltas by the test sequence
  int rises = 0, falls = 0, vhi = 0, ferrs = 0, ovrs = 0, perrs = 0, busyc = 0, stab_err = 0;
  int rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic [7:0] dprev = 8'h00;
  logic vprev = 1'b0;
  logic rprev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      vprev = 1'b0;
      rprev = 1'b0;
    end else begin
      if (bus.data_valid && !vprev) begin
        rises++;
        rise_cyc  = cyc;
        rise_data = bus.data_out;
      end
      if (!bus.data_valid && vprev) falls++;
      if (bus.data_valid && vprev && !rprev && (bus.data_out != dprev)) stab_err++;
      if (bus.data_valid) vhi++;
      if (bus.frame_err) ferrs++;
      if (bus.overrun) ovrs++;
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err) perrs++;
`endif
      if (bus.busy) busyc++;
      vprev = bus.data_valid;
      rprev = bus.data_ready;
      dprev = bus.data_out;
    end
  end

  int tests = 0;
  int failed = 0;
  int fall_cyc = 0;
  int s_rises, s_falls, s_vhi, s_ferrs, s_ovrs, s_perrs, s_busyc;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_rises = rises; s_falls = falls; s_vhi = vhi; s_ferrs = ferrs;
    s_ovrs = ovrs; s_perrs = perrs; s_busyc = busyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    fall_cyc = cyc;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (16) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = (^d) ^ bad_par;
    repeat (16) @(posedge clk);
`endif
    #1 rx = stop;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h6E, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

    rx = 1'b1;
    reset = 1'b1;
    bus.data_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    bad_par = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    idle(5);

    // Single frames with ready held high
    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop);
      idle(10);
      check("tbl_valid_count", 32'(rises - s_rises), 32'(vecs[i].exp_valid));
      check("tbl_frame_err", 32'(ferrs - s_ferrs), 32'(vecs[i].exp_ferr));
      check("tbl_overrun", 32'(ovrs - s_ovrs), 32'h0);
      check("tbl_parity_err", 32'(perrs - s_perrs), 32'h0);
      if (vecs[i].exp_valid) begin
        check("tbl_data", 32'(rise_data), 32'(vecs[i].data));
        check("tbl_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
        check("tbl_valid_width", 32'(vhi - s_vhi), 32'h1);
      end
      check("tbl_busy_end", 32'(bus.busy), 32'h0);
    end

    // Short low glitch on an idle line
    snap();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    idle(20);
    check("glitch_valid", 32'(rises - s_rises), 32'h0);
    check("glitch_busy_range", 32'((busyc - s_busyc) >= 1 && (busyc - s_busyc) <= 10), 32'h1);
    check("glitch_busy_end", 32'(bus.busy), 32'h0);

    // Overrun: ready low, two back-to-back frames
    bus.data_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("ovr_pulse", 32'(ovrs - s_ovrs), 32'h1);
    check("ovr_data_kept", 32'(bus.data_out), 32'h11);
    check("ovr_valid_held", 32'(bus.data_valid), 32'h1);
    @(posedge clk);
    #1 bus.data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_drain", 32'(bus.data_valid), 32'h0);
    idle(5);

    // Ready raised exactly on the completing cycle of the second word
    bus.data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(5);
    snap();
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 bus.data_ready = 1'b1;
        @(posedge clk);
        #1 bus.data_ready = 1'b0;
      end
    join
    idle(10);
    check("handoff_data", 32'(bus.data_out), 32'h22);
    check("handoff_valid", 32'(bus.data_valid), 32'h1);
    check("handoff_no_gap", 32'(falls - s_falls), 32'h0);
    check("handoff_no_ovr", 32'(ovrs - s_ovrs), 32'h0);
    bus.data_ready = 1'b1;
    idle(5);
    check("handoff_drain", 32'(bus.data_valid), 32'h0);

    // Reset in the middle of a frame, then a clean frame
    snap();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_valid", 32'(bus.data_valid), 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
      end
    join
    idle(10);
    check("midrst_no_word", 32'(rises - s_rises), 32'h0);
    check("midrst_no_ferr", 32'(ferrs - s_ferrs), 32'h0);
    snap();
    send_frame(8'h5A, 1'b1);
    idle(10);
    check("post_rst_count", 32'(rises - s_rises), 32'h1);
    check("post_rst_data", 32'(rise_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    // Wrong even-parity bit
    snap();
    bad_par = 1'b1;
    send_frame(8'h5A, 1'b1);
    bad_par = 1'b0;
    idle(10);
    check("par_err_pulse", 32'(perrs - s_perrs), 32'h1);
    check("par_no_valid", 32'(rises - s_rises), 32'h0);
    check("par_no_ferr", 32'(ferrs - s_ferrs), 32'h0);
`endif

    check("data_out_stable", 32'(stab_err), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
